// File: rtl/inst_queue_param_pkg.sv
// -----------------------------------------------------------------------------
// inst_queue_param_pkg
// Shared constants for the IF->ID instruction queue: default depth and skid
// reserve, instruction/address bus widths, and the valid/full flag encodings.
// Optional feature macro used by the queue: IQ_EMPTY_BYPASS_EN.
// -----------------------------------------------------------------------------
package inst_queue_param_pkg;

   localparam int unsigned IQ_DEPTH_DEFAULT = 16;
   localparam int unsigned IQ_SKID_DEFAULT  = 2;
   localparam int unsigned IQ_INST_W        = 32;
   localparam int unsigned IQ_ADDR_W        = 32;

   typedef enum logic {
      IQ_INVALID = 1'b0,
      IQ_VALID   = 1'b1
   } iq_valid_e;

   typedef enum logic {
      IQ_NOT_FULL = 1'b0,
      IQ_FULL     = 1'b1
   } iq_full_e;

endpackage

// File: rtl/inst_queue_param_iq_storage.sv
// -----------------------------------------------------------------------------
// iq_storage
// DEPTH x WIDTH register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write slot
//   wdata  - write data
//   raddr  - read slot
//   rdata  - combinational read data
// -----------------------------------------------------------------------------
module iq_storage
   import inst_queue_param_pkg::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH_DEFAULT,
   parameter int unsigned WIDTH = IQ_INST_W + IQ_ADDR_W + 1
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue_param.sv
// -----------------------------------------------------------------------------
// inst_queue_param
// Circular instruction queue between fetch (IF) and decode (ID) with
// first-word-fall-through head, ready/valid dequeue, almost-full back-pressure
// and an occupancy output.
// Optional feature macro: IQ_EMPTY_BYPASS_EN (zero-latency pass-through of
// if_* to id_* while the queue is empty).
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   rdy                 - global enable; 0 freezes pointers and count
//   clear               - synchronous flush, overrides push/pop, ignores rdy
//   if_valid/inst/pc/pred_taken - fetch side entry
//   full                - asserted when count >= DEPTH-SKID
//   id_ready            - decode accepts the head
//   id_valid/inst/pc/pred_taken - head entry, zero when not valid
//   count               - current occupancy
// -----------------------------------------------------------------------------
module inst_queue_param
   import inst_queue_param_pkg::*;
#(
   parameter int unsigned DEPTH  = IQ_DEPTH_DEFAULT,
   parameter int unsigned INST_W = IQ_INST_W,
   parameter int unsigned ADDR_W = IQ_ADDR_W,
   parameter int unsigned SKID   = IQ_SKID_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       clear,
   input  logic                       if_valid,
   input  logic [INST_W-1:0]          if_inst,
   input  logic [ADDR_W-1:0]          if_pc,
   input  logic                       if_pred_taken,
   output logic                       full,
   input  logic                       id_ready,
   output logic                       id_valid,
   output logic [INST_W-1:0]          id_inst,
   output logic [ADDR_W-1:0]          id_pc,
   output logic                       id_pred_taken,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned EW = INST_W + ADDR_W + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
   localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - SKID);

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic          active;
   logic          stored_valid;
   logic          byp;
   logic          push;
   logic          pop;
   logic [EW-1:0] wr_entry;
   logic [EW-1:0] rd_entry;
   logic [EW-1:0] out_entry;

   assign active       = rdy && !clear;
   assign stored_valid = (count_q != '0);
   assign wr_entry     = {if_inst, if_pc, if_pred_taken};

`ifdef IQ_EMPTY_BYPASS_EN
   assign byp = active && if_valid && !stored_valid;
`else
   assign byp = 1'b0;
`endif

   // A push at capacity is still legal when the head leaves in the same cycle:
   // tail==head there, so the new entry lands in the slot being freed.
   assign pop  = active && stored_valid && id_ready;
   assign push = active && if_valid && ((count_q != CNT_MAX) || pop)
                 && !(byp && id_ready);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop) begin
         head_d = head_q + PW'(1);
      end
      if (push) begin
         tail_d = tail_q + PW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (clear) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   iq_storage #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_storage (
      .clk   (clk),
      .we    (push),
      .waddr (tail_q),
      .wdata (wr_entry),
      .raddr (head_q),
      .rdata (rd_entry)
   );

   always_comb begin
      out_entry = '0;
      if (stored_valid) begin
         out_entry = rd_entry;
      end else if (byp) begin
         out_entry = wr_entry;
      end
   end

   assign id_valid      = (stored_valid || byp) ? IQ_VALID : IQ_INVALID;
   assign id_inst       = out_entry[EW-1 -: INST_W];
   assign id_pc         = out_entry[ADDR_W:1];
   assign id_pred_taken = out_entry[0];
   assign full          = (count_q >= FULL_TH) ? IQ_FULL : IQ_NOT_FULL;
   assign count         = count_q;

`ifndef SYNTHESIS
   // IF is expected to honour full; a dropped push is flagged, not fatal.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_chk: assert (!(active && if_valid && (count_q == CNT_MAX) && !pop))
            else $warning("inst_queue_param: push dropped, queue at capacity");
      end
   end
`endif

endmodule

// File: tb/tb_inst_queue_param.sv
module tb_inst_queue_param;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        pt;
   } ent_t;

   // Two configurations share the stimulus: index 0 is DEPTH=4/SKID=1,
   // index 1 is DEPTH=8/SKID=2.
   ent_t mq [2][$];
   int   dep [2] = '{4, 8};
   int   skd [2] = '{1, 2};

   int n_tests = 0;
   int n_fail  = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        clear = 1'b0;
   logic        if_valid = 1'b0;
   logic [31:0] if_inst = '0;
   logic [31:0] if_pc = '0;
   logic        if_pt = 1'b0;
   logic        id_ready = 1'b0;

   logic        o_full  [2];
   logic        o_valid [2];
   logic [31:0] o_inst  [2];
   logic [31:0] o_pc    [2];
   logic        o_pt    [2];
   logic [2:0]  cnt4;
   logic [3:0]  cnt8;

   always #5 clk = ~clk;

   inst_queue_param #(.DEPTH(4), .INST_W(32), .ADDR_W(32), .SKID(1)) u_dut4 (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pred_taken(if_pt),
      .full(o_full[0]), .id_ready(id_ready), .id_valid(o_valid[0]),
      .id_inst(o_inst[0]), .id_pc(o_pc[0]), .id_pred_taken(o_pt[0]), .count(cnt4)
   );

   inst_queue_param #(.DEPTH(8), .INST_W(32), .ADDR_W(32), .SKID(2)) u_dut8 (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pred_taken(if_pt),
      .full(o_full[1]), .id_ready(id_ready), .id_valid(o_valid[1]),
      .id_inst(o_inst[1]), .id_pc(o_pc[1]), .id_pred_taken(o_pt[1]), .count(cnt8)
   );

   function automatic logic [63:0] dut_count(int k);
      return (k == 0) ? 64'(cnt4) : 64'(cnt8);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_empty(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s d%0d valid", tag, dep[k]), 64'(o_valid[k]), 64'd0);
         check($sformatf("%s d%0d count", tag, dep[k]), dut_count(k), 64'd0);
         check($sformatf("%s d%0d full", tag, dep[k]), 64'(o_full[k]), 64'd0);
         check($sformatf("%s d%0d inst", tag, dep[k]), 64'(o_inst[k]), 64'd0);
      end
   endtask

   // Compare outputs against the model's pre-edge view, advance the model by
   // the queue rules, then take the clock edge. Called at a negedge.
   task automatic step(input string tag);
      #1;
      for (int k = 0; k < 2; k++) begin
         int   cnt;
         logic byp;
         logic pop;
         logic [31:0] e_inst;
         logic [31:0] e_pc;
         logic        e_pt;
         cnt = mq[k].size();
`ifdef IQ_EMPTY_BYPASS_EN
         byp = (cnt == 0) && if_valid && rdy && !clear;
`else
         byp = 1'b0;
`endif
         e_inst = '0; e_pc = '0; e_pt = 1'b0;
         if (cnt != 0) begin
            e_inst = mq[k][0].inst; e_pc = mq[k][0].pc; e_pt = mq[k][0].pt;
         end else if (byp) begin
            e_inst = if_inst; e_pc = if_pc; e_pt = if_pt;
         end
         check($sformatf("%s d%0d valid", tag, dep[k]), 64'(o_valid[k]), 64'((cnt != 0) || byp));
         check($sformatf("%s d%0d inst", tag, dep[k]), 64'(o_inst[k]), 64'(e_inst));
         check($sformatf("%s d%0d pc", tag, dep[k]), 64'(o_pc[k]), 64'(e_pc));
         check($sformatf("%s d%0d pred", tag, dep[k]), 64'(o_pt[k]), 64'(e_pt));
         check($sformatf("%s d%0d count", tag, dep[k]), dut_count(k), 64'(cnt));
         check($sformatf("%s d%0d full", tag, dep[k]), 64'(o_full[k]), 64'(cnt >= dep[k] - skd[k]));

         if (clear) begin
            mq[k].delete();
         end else if (rdy && !(byp && id_ready)) begin
            pop = (cnt != 0) && id_ready;
            if (pop) void'(mq[k].pop_front());
            if (if_valid && (cnt < dep[k] || pop)) begin
               ent_t e;
               e.inst = if_inst; e.pc = if_pc; e.pt = if_pt;
               mq[k].push_back(e);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic rd);
      if_valid = v;
      if_pc    = pc;
      if_inst  = $urandom;
      if_pt    = 1'($urandom % 2);
      id_ready = rd;
   endtask

   initial begin
      // Power-on reset.
      #2 rst = 1'b0;
      #1 check_empty("reset");
      @(negedge clk) rst = 1'b1;

      // Reset mid-stream.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h200 + 32'(4 * i), 1'b0);
         step("pre-rst push");
      end
      drive(1'b0, '0, 1'b0);
      @(posedge clk);
      #3 rst = 1'b0;
      #1 check_empty("async rst");
      for (int k = 0; k < 2; k++) mq[k].delete();
      @(negedge clk) rst = 1'b1;

      // Fill with id_ready low, then one overflow push (dropped by depth 4).
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h100 + 32'(4 * i), 1'b0);
         step("fill");
      end
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, '0, 1'b1);
         step("drain");
      end

      // Steady count=2 across pointer wrap.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h300 + 32'(4 * i), 1'b0);
         step("wrap pre");
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h308 + 32'(4 * i), 1'b1);
         step("wrap");
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, 1'b1);
         step("wrap drain");
      end

      // Push+pop while depth-4 queue is at capacity.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h400 + 32'(4 * i), 1'b0);
         step("cap fill");
      end
      drive(1'b1, 32'h4F0, 1'b1);
      step("cap pushpop");
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, '0, 1'b1);
         step("cap drain");
      end

      // Flush with rdy low and an entry presented.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h500 + 32'(4 * i), 1'b0);
         step("flush fill");
      end
      drive(1'b1, 32'h5F0, 1'b1);
      rdy = 1'b0; clear = 1'b1;
      step("flush");
      rdy = 1'b1; clear = 1'b0;
      drive(1'b0, '0, 1'b0);
      step("post flush");

      // rdy low freezes state.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h600 + 32'(4 * i), 1'b0);
         step("hold fill");
      end
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h6F0, 1'b1);
         step("hold");
      end
      rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, 1'b1);
         step("hold drain");
      end

      // Empty queue presented an entry with id_ready high.
      drive(1'b1, 32'h700, 1'b1);
      if_inst = 32'h0000_0013;
      step("empty push");
      drive(1'b0, '0, 1'b0);
      step("empty next");
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, '0, 1'b1);
         step("empty drain");
      end

      // Randomized traffic; IF never overruns a full queue.
      for (int i = 0; i < 400; i++) begin
         rdy   = ($urandom % 8) != 0;
         clear = ($urandom % 32) == 0;
         drive(($urandom % 4) != 0, $urandom, 1'($urandom % 2));
         if (mq[0].size() >= dep[0] && !(id_ready && rdy)) if_valid = 1'b0;
         if (mq[1].size() >= dep[1] && !(id_ready && rdy)) if_valid = 1'b0;
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
